// File: rtl/bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_addsub
// Brief    : Digit-serial packed-BCD adder/subtractor, one digit per clock,
//            least-significant digit first. Define BCD_SUB_EN to enable the
//            ten's-complement subtraction path.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                sub,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    localparam int c_WIDTH = 4 * DIGITS;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        c_ST_IDLE = 2'd0,
        c_ST_RUN  = 2'd1,
        c_ST_DONE = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [c_WIDTH-1:0] r_a_q, w_a_d;
    logic [c_WIDTH-1:0] r_b_q, w_b_d;
    logic [c_WIDTH-1:0] r_sum_q, w_sum_d;
    logic [c_IDX_W-1:0] r_idx_q, w_idx_d;
    logic               r_carry_q, w_carry_d;
    logic               r_cout_q, w_cout_d;
    logic               r_err_q, w_err_d;
    logic               r_busy_q, w_busy_d;
    logic               r_done_q, w_done_d;
    logic               w_sub_start;
    logic [3:0]         w_a_dig, w_b_dig, w_bd, w_sum_dig;
    logic [4:0]         w_t;
    logic               w_carry_nxt;

`ifdef BCD_SUB_EN
    logic               r_sub_q, w_sub_d;
    assign w_sub_start = sub;
`else
    // Port kept for pin compatibility; addition only.
    logic               w_sub_unused;
    assign w_sub_unused = sub;
    assign w_sub_start  = 1'b0;
`endif

    function automatic logic has_bad_digit(input logic [c_WIDTH-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Single-digit BCD add of the digit selected by the index.
    always_comb begin
        w_a_dig = r_a_q[{r_idx_q, 2'b00} +: 4];
        w_b_dig = r_b_q[{r_idx_q, 2'b00} +: 4];
`ifdef BCD_SUB_EN
        w_bd    = r_sub_q ? (4'd9 - w_b_dig) : w_b_dig;
`else
        w_bd    = w_b_dig;
`endif
        w_t     = {1'b0, w_a_dig} + {1'b0, w_bd} + {4'd0, r_carry_q};
        if (w_t > 5'd9) begin
            w_sum_dig   = w_t[3:0] + 4'd6;
            w_carry_nxt = 1'b1;
        end else begin
            w_sum_dig   = w_t[3:0];
            w_carry_nxt = 1'b0;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_sum_d   = r_sum_q;
        w_idx_d   = r_idx_q;
        w_carry_d = r_carry_q;
        w_cout_d  = r_cout_q;
        w_err_d   = r_err_q;
`ifdef BCD_SUB_EN
        w_sub_d   = r_sub_q;
`endif
        case (r_state_q)
            c_ST_IDLE, c_ST_DONE: begin
                if (start) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_carry_d = w_sub_start;
                    w_idx_d   = '0;
                    w_err_d   = has_bad_digit(a) | has_bad_digit(b);
`ifdef BCD_SUB_EN
                    w_sub_d   = sub;
`endif
                    w_state_d = c_ST_RUN;
                end else begin
                    w_state_d = c_ST_IDLE;
                end
            end
            c_ST_RUN: begin
                w_sum_d[{r_idx_q, 2'b00} +: 4] = w_sum_dig;
                w_carry_d = w_carry_nxt;
                if (r_idx_q == c_LAST_IDX) begin
                    w_cout_d  = w_carry_nxt;
                    w_state_d = c_ST_DONE;
                end else begin
                    w_idx_d   = r_idx_q + 1'b1;
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
        w_busy_d = (w_state_d == c_ST_RUN);
        w_done_d = (r_state_q == c_ST_RUN) && (w_state_d == c_ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= c_ST_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_sum_q   <= '0;
            r_idx_q   <= '0;
            r_carry_q <= 1'b0;
            r_cout_q  <= 1'b0;
            r_err_q   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
`ifdef BCD_SUB_EN
            r_sub_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_sum_q   <= w_sum_d;
            r_idx_q   <= w_idx_d;
            r_carry_q <= w_carry_d;
            r_cout_q  <= w_cout_d;
            r_err_q   <= w_err_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
`ifdef BCD_SUB_EN
            r_sub_q   <= w_sub_d;
`endif
        end
    end

    assign busy = r_busy_q;
    assign done = r_done_q;
    assign sum  = r_sum_q;
    assign cout = r_cout_q;
    assign err  = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_addsub
// Brief    : Self-checking bench for bcd_serial_addsub against an integer
//            decimal reference model; honours BCD_SUB_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_addsub;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n, start, sub;
    logic         busy, done, cout, err;
    logic [W-1:0] a, b, sum;
    int           passed = 0;
    int           total  = 0;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r;
        longint       x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Decimal reference: plain integer add/subtract modulo 10^D.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic ms, output logic [W-1:0] rs, output logic rc);
        longint m = 1;
        longint x;
        logic   eff_sub;
`ifdef BCD_SUB_EN
        eff_sub = ms;
`else
        eff_sub = ms & 1'b0;
`endif
        for (int i = 0; i < D; i++) m = m * 10;
        if (eff_sub) begin
            x  = bcd2int(ma) - bcd2int(mb);
            rc = (x >= 0);
            if (x < 0) x = x + m;
        end else begin
            x  = bcd2int(ma) + bcd2int(mb);
            rc = (x >= m);
            if (x >= m) x = x - m;
        end
        rs = int2bcd(x);
    endfunction

    // Drives one operation and waits (bounded) for done; lat=0 means timeout.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                         output logic [W-1:0] rs, output logic rc, output logic re,
                         output int lat, output int bcnt);
        @(negedge clk);
        a = oa; b = ob; sub = os; start = 1'b1;
        lat = 0; bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        rs = sum; rc = cout; re = err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
        total++; if (sum !== '0) $display("FAIL reset_sum got %h exp 0", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b exp 0", cout); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed_add();
        logic [W-1:0] s; logic c, e; int lat, bc;
        do_op(16'h1234, 16'h5678, 1'b0, s, c, e, lat, bc);
        total++; if (s !== 16'h6912) $display("FAIL add_sum got %h exp 6912", s); else passed++;
        total++; if (c !== 1'b0) $display("FAIL add_cout got %b exp 0", c); else passed++;
        total++; if (e !== 1'b0) $display("FAIL add_err got %b exp 0", e); else passed++;
        total++; if (lat != D + 1) $display("FAIL add_latency got %0d exp %0d", lat, D + 1); else passed++;
        total++; if (bc != D) $display("FAIL add_busy_cycles got %0d exp %0d", bc, D); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL add_done_pulse got %b exp 0", done); else passed++;
        do_op(16'h9999, 16'h0001, 1'b0, s, c, e, lat, bc);
        total++; if (s !== 16'h0000) $display("FAIL ripple_sum got %h exp 0000", s); else passed++;
        total++; if (c !== 1'b1) $display("FAIL ripple_cout got %b exp 1", c); else passed++;
    endtask

    task automatic test_sub();
        logic [W-1:0] s, e1, e2; logic c, e, c1, c2; int lat, bc;
`ifdef BCD_SUB_EN
        e1 = 16'h0377; c1 = 1'b1; e2 = 16'h9623; c2 = 1'b0;
`else
        e1 = 16'h0623; c1 = 1'b0; e2 = 16'h0623; c2 = 1'b0;
`endif
        do_op(16'h0500, 16'h0123, 1'b1, s, c, e, lat, bc);
        total++; if (s !== e1) $display("FAIL sub_sum got %h exp %h", s, e1); else passed++;
        total++; if (c !== c1) $display("FAIL sub_cout got %b exp %b", c, c1); else passed++;
        do_op(16'h0123, 16'h0500, 1'b1, s, c, e, lat, bc);
        total++; if (s !== e2) $display("FAIL sub_swap_sum got %h exp %h", s, e2); else passed++;
        total++; if (c !== c2) $display("FAIL sub_swap_cout got %b exp %b", c, c2); else passed++;
    endtask

    task automatic test_err();
        logic [W-1:0] s; logic c, e; int lat, bc;
        do_op(16'h00A1, 16'h0001, 1'b0, s, c, e, lat, bc);
        total++; if (e !== 1'b1) $display("FAIL err_set got %b exp 1", e); else passed++;
        total++; if (lat != D + 1) $display("FAIL err_latency got %0d exp %0d", lat, D + 1); else passed++;
        do_op(16'h0042, 16'h0007, 1'b0, s, c, e, lat, bc);
        total++; if (e !== 1'b0) $display("FAIL err_clear got %b exp 0", e); else passed++;
        total++; if (s !== 16'h0049) $display("FAIL err_clear_sum got %h exp 0049", s); else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, s, es; logic rs, c, e, ec; int lat, bc;
        for (int n = 0; n < 24; n++) begin
            ra = rand_bcd(); rb = rand_bcd(); rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, es, ec);
            do_op(ra, rb, rs, s, c, e, lat, bc);
            total++; if (s !== es || c !== ec || e !== 1'b0 || lat != D + 1)
                $display("FAIL rand_%0d a=%h b=%h sub=%b got sum=%h cout=%b err=%b lat=%0d exp sum=%h cout=%b err=0 lat=%0d",
                         n, ra, rb, rs, s, c, e, lat, es, ec, D + 1);
            else passed++;
        end
        for (int n = 0; n < 6; n++) begin
            ra = rand_bcd(); rb = rand_bcd();
            if (n[0]) ra[4*(n % D) +: 4] = 4'($urandom_range(10, 15));
            else      rb[4*(n % D) +: 4] = 4'($urandom_range(10, 15));
            do_op(ra, rb, 1'b0, s, c, e, lat, bc);
            total++; if (e !== 1'b1 || lat != D + 1)
                $display("FAIL rand_err_%0d a=%h b=%h got err=%b lat=%0d exp err=1 lat=%0d", n, ra, rb, e, lat, D + 1);
            else passed++;
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] s; logic c; int nd;
        @(negedge clk); a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 16'h9999; b = 16'h9999; sub = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        nd = 0; s = '0; c = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (done) begin nd++; s = sum; c = cout; end
            @(negedge clk);
        end
        total++; if (nd != 1) $display("FAIL ignore_done_count got %0d exp 1", nd); else passed++;
        total++; if (s !== 16'h6912 || c !== 1'b0)
            $display("FAIL ignore_result got %h/%b exp 6912/0", s, c); else passed++;
        total++; if (sum !== 16'h6912) $display("FAIL ignore_hold got %h exp 6912", sum); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int nd;
        @(negedge clk); a = 16'h9A99; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || err !== 1'b0)
            $display("FAIL midrst_outputs got busy=%b done=%b sum=%h cout=%b err=%b exp all 0",
                     busy, done, sum, cout, err);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        total++; if (nd != 0) $display("FAIL midrst_no_done got %0d active cycles exp 0", nd); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s1; logic c1; int k1, k2;
        @(negedge clk); a = 16'h4321; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k1 = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin k1 = 1; break; end
            @(negedge clk);
        end
        s1 = sum; c1 = cout;
        a = 16'h5000; b = 16'h5000; start = 1'b1;
        @(negedge clk);
        total++; if (k1 != 1 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_restart got seen=%0d busy=%b done=%b exp 1/1/0", k1, busy, done);
        else passed++;
        start = 1'b0;
        k2 = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin k2 = k; break; end
        end
        total++; if (k2 != D + 1) $display("FAIL b2b_spacing got %0d exp %0d", k2, D + 1); else passed++;
        total++; if (s1 !== 16'h5432 || c1 !== 1'b0) $display("FAIL b2b_first got %h/%b exp 5432/0", s1, c1); else passed++;
        total++; if (sum !== 16'h0000 || cout !== 1'b1) $display("FAIL b2b_second got %h/%b exp 0000/1", sum, cout); else passed++;
    endtask

    initial begin
        test_reset();
        test_directed_add();
        test_sub();
        test_err();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
